// File: rtl/div_unit.sv
// div_unit: iterative 32-bit radix-2 restoring divider for MIPS DIV/DIVU.
// Produces {hi = remainder, lo = quotient} 33 cycles after issue and
// requests a pipeline stall while it iterates.
// Optional feature macro: DIV_ZERO_FAST_EN. When it is defined, a zero
// divisor skips the iterations and finishes one cycle after issue.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic        flush,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        ready,
  output logic [63:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Two's complement negation when en is set, pass-through otherwise.
  function automatic logic [31:0] neg_if(input logic [31:0] val, input logic en);
    logic [31:0] res;
    if (en) begin
      res = 32'd0 - val;
    end else begin
      res = val;
    end
    return res;
  endfunction

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic        ready_q, ready_d;
  logic [63:0] result_q, result_d;

  logic [32:0] shift_s;
  logic [32:0] trial_s;
  logic [31:0] rem_next_s;
  logic [31:0] quo_next_s;
  logic        b_zero_s;
  logic        a_neg_s;
  logic        b_neg_s;

  // One restoring step: shift in the next dividend bit and try the subtract.
  always_comb begin
    shift_s    = {rem_q, quo_q[31]};
    trial_s    = shift_s - {1'b0, dvs_q};
    quo_next_s = {quo_q[30:0], ~trial_s[32]};
    if (trial_s[32]) begin
      rem_next_s = shift_s[31:0];
    end else begin
      rem_next_s = trial_s[31:0];
    end
  end

  // Operand classification for the issue cycle. A zero divisor keeps the
  // raw dividend and no sign fixup so the remainder comes out equal to a.
  always_comb begin
    b_zero_s = (b == 32'd0);
    a_neg_s  = signed_div & a[31] & ~b_zero_s;
    b_neg_s  = signed_div & b[31];
  end

  // Next-state, datapath updates and stall request.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    ready_d  = 1'b0;
    result_d = result_q;
    busy     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start & ~flush) begin
          busy    = 1'b1;
          quo_d   = neg_if(a, a_neg_s);
          dvs_d   = neg_if(b, b_neg_s);
          q_neg_d = a_neg_s ^ b_neg_s;
          r_neg_d = a_neg_s;
          rem_d   = 32'd0;
          cnt_d   = 5'd0;
`ifdef DIV_ZERO_FAST_EN
          if (b_zero_s) begin
            state_d  = S_DONE;
            ready_d  = 1'b1;
            result_d = {a, 32'hFFFF_FFFF};
          end else begin
            state_d = S_BUSY;
          end
`else
          state_d = S_BUSY;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        busy = 1'b1;
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_next_s;
          quo_d = quo_next_s;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d  = S_DONE;
            ready_d  = 1'b1;
            result_d = {neg_if(rem_next_s, r_neg_q), neg_if(quo_next_s, q_neg_q)};
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // No stall request while the unit is being reset.
    if (rst) begin
      busy = 1'b0;
    end else begin
      busy = busy;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      dvs_q    <= 32'd0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= 64'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end

  assign ready  = ready_q;
  assign result = result_q;

endmodule
